shift_reg_siso: RTL and testbench

SHIFT_REG_SISO -- requirements
Module: shift_reg_siso

---
 rtl/shift_reg_siso.sv | 79 +++++++
 tb/tb_shift_reg_siso.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_siso.sv
// shift_reg_siso: serial-in / serial-out shift register of DEPTH flops.
// sdo is taken straight from the last stage flop, so sdi never reaches sdo
// combinationally. A bit entering on one edge appears on sdo after
// DEPTH-1 further edges and holds for one cycle.
//
// Optional feature, enabled by defining SHIFT_REG_SISO_TAP_EN:
//   taps     - parallel view of every stage (taps[i] = stage[i])
//   ones_cnt - registered count of 1 bits currently held in the stages
// With the macro undefined, the port list is exactly clk, reset, sdi, sdo.
module shift_reg_siso #(
  parameter int   DEPTH     = 4,    // number of stages, legal 1..64
  parameter logic RESET_VAL = 1'b0  // value loaded into every stage on reset
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sdi,
  output logic                           sdo
`ifdef SHIFT_REG_SISO_TAP_EN
  ,
  output logic [DEPTH-1:0]               taps,
  output logic [$clog2(DEPTH+1)-1:0]     ones_cnt
`endif
);

  // Stage 0 is the input end, stage DEPTH-1 drives sdo.
  logic [DEPTH-1:0] r_stage;
  logic [DEPTH-1:0] w_stage_nxt;

  // Next-state of the chain: sdi enters stage 0, every other stage takes its
  // neighbour. Written as a loop so DEPTH=1 degenerates to a single flop.
  always_comb begin
    w_stage_nxt    = r_stage;
    w_stage_nxt[0] = sdi;
    for (int i = 1; i < DEPTH; i++) begin
      w_stage_nxt[i] = r_stage[i-1];
    end
  end

  // Shift on every edge; reset wins over shifting and ignores sdi.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage <= {DEPTH{RESET_VAL}};
    end else begin
      r_stage <= w_stage_nxt;
    end
  end

  assign sdo = r_stage[DEPTH-1];

`ifdef SHIFT_REG_SISO_TAP_EN
  localparam int CW = $clog2(DEPTH+1);

  logic [CW-1:0] r_ones_cnt;

  // Population count of a stage vector.
  function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  // Count is computed from the next stage vector so it lands on the same
  // edge as the stages themselves and always agrees with taps.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ones_cnt <= RESET_VAL ? CW'(DEPTH) : '0;
    end else begin
      r_ones_cnt <= popcount(w_stage_nxt);
    end
  end

  assign taps     = r_stage;
  assign ones_cnt = r_ones_cnt;
`endif

endmodule

// File: tb/tb_shift_reg_siso.sv
// Directed bench for shift_reg_siso: reset, single/double pulse, pattern,
// mid-stream reset, between-edge reset glitch and a random sweep over
// DEPTH = 1, 4 and 16 plus a DEPTH=4, RESET_VAL=1 instance.
module tb_shift_reg_siso;

  logic clk = 1'b0;
  logic reset;
  logic sdi;

  logic sdo4, sdo1, sdo16, sdo4r1;

`ifdef SHIFT_REG_SISO_TAP_EN
  logic [3:0]  taps4;
  logic [2:0]  cnt4;
  logic [0:0]  taps1;
  logic [0:0]  cnt1;
  logic [15:0] taps16;
  logic [4:0]  cnt16;
  logic [3:0]  taps4r1;
  logic [2:0]  cnt4r1;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Inputs seen on shift edges since the last reset edge (1-based).
  logic hist [0:255];
  int   n;

  always #5 clk = ~clk;

  shift_reg_siso #(.DEPTH(4), .RESET_VAL(1'b0)) u_d4 (
    .clk(clk), .reset(reset), .sdi(sdi), .sdo(sdo4)
`ifdef SHIFT_REG_SISO_TAP_EN
    , .taps(taps4), .ones_cnt(cnt4)
`endif
  );

  shift_reg_siso #(.DEPTH(1), .RESET_VAL(1'b0)) u_d1 (
    .clk(clk), .reset(reset), .sdi(sdi), .sdo(sdo1)
`ifdef SHIFT_REG_SISO_TAP_EN
    , .taps(taps1), .ones_cnt(cnt1)
`endif
  );

  shift_reg_siso #(.DEPTH(16), .RESET_VAL(1'b0)) u_d16 (
    .clk(clk), .reset(reset), .sdi(sdi), .sdo(sdo16)
`ifdef SHIFT_REG_SISO_TAP_EN
    , .taps(taps16), .ones_cnt(cnt16)
`endif
  );

  shift_reg_siso #(.DEPTH(4), .RESET_VAL(1'b1)) u_d4r1 (
    .clk(clk), .reset(reset), .sdi(sdi), .sdo(sdo4r1)
`ifdef SHIFT_REG_SISO_TAP_EN
    , .taps(taps4r1), .ones_cnt(cnt4r1)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive sdi, take one rising edge, then settle 1 time unit past the edge.
  task automatic step(input logic d);
    sdi = d;
    @(posedge clk);
    #1;
  endtask

  // Expected sdo for a RESET_VAL=0 instance of depth d after n shift edges.
  function automatic logic exp_sdo(input int d);
    if (n - d + 1 >= 1) return hist[n-d+1];
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_cnt(input int d);
    logic [31:0] c;
    c = 0;
    for (int j = n - d + 1; j <= n; j++) begin
      if (j >= 1 && hist[j]) c = c + 1;
    end
    return c;
  endfunction

  initial begin
    logic [6:0]  pin, pexp, pexp_r1;
    logic [10:0] pat_in, pat_exp;
    logic [2:0]  pat_cnt [0:10];
    logic        b;

    reset = 1'b1;
    sdi   = 1'b1;

    // Reset held for two edges with sdi=1.
    for (int e = 0; e < 2; e++) begin
      step(1'b1);
      check_val("rst_sdo4",   32'(sdo4),   32'd0);
      check_val("rst_sdo1",   32'(sdo1),   32'd0);
      check_val("rst_sdo16",  32'(sdo16),  32'd0);
      check_val("rst_sdo4r1", 32'(sdo4r1), 32'd1);
`ifdef SHIFT_REG_SISO_TAP_EN
      check_val("rst_taps4",   32'(taps4),   32'h0);
      check_val("rst_cnt4",    32'(cnt4),    32'd0);
      check_val("rst_taps4r1", 32'(taps4r1), 32'hF);
      check_val("rst_cnt4r1",  32'(cnt4r1),  32'd4);
`endif
    end

    // Single pulse right after release. RESET_VAL=1 instance shows three
    // cycles of reset value before the pulse and then the zeros.
    reset   = 1'b0;
    pin     = 7'b1000000;
    pexp    = 7'b0001000;
    pexp_r1 = 7'b1111000;
    for (int i = 6; i >= 0; i--) begin
      step(pin[i]);
      check_val("pulse_sdo4",   32'(sdo4),   32'(pexp[i]));
      check_val("pulse_sdo4r1", 32'(sdo4r1), 32'(pexp_r1[i]));
    end

    // Two-cycle pulse.
    pin  = 7'b1100000;
    pexp = 7'b0001100;
    for (int i = 6; i >= 0; i--) begin
      step(pin[i]);
      check_val("pulse2_sdo4", 32'(sdo4), 32'(pexp[i]));
    end

    // Pattern 1,0,1,1,0,0,1 followed by zeros; sdo lags by 4 stages.
    pat_in  = 11'b1011001_0000;
    pat_exp = 11'b0001011_0010;
    pat_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd0};
    for (int i = 10; i >= 0; i--) begin
      step(pat_in[i]);
      check_val("pat_sdo4", 32'(sdo4), 32'(pat_exp[i]));
`ifdef SHIFT_REG_SISO_TAP_EN
      check_val("pat_cnt4", 32'(cnt4), 32'(pat_cnt[10-i]));
      if (i == 7) check_val("pat_taps4", 32'(taps4), 32'b1011);
`endif
    end

    // Load 1111, then glitch reset between edges: no effect.
    for (int i = 0; i < 4; i++) step(1'b1);
    check_val("load_sdo4", 32'(sdo4), 32'd1);
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check_val("glitch_mid_sdo4", 32'(sdo4), 32'd1);
    step(1'b1);
    check_val("glitch_edge_sdo4", 32'(sdo4), 32'd1);
`ifdef SHIFT_REG_SISO_TAP_EN
    check_val("glitch_cnt4", 32'(cnt4), 32'd4);
`endif

    // Mid-stream reset for one edge with sdi=1, then sdi=0: nothing emerges.
    reset = 1'b1;
    step(1'b1);
    check_val("mid_rst_sdo4",   32'(sdo4),   32'd0);
    check_val("mid_rst_sdo4r1", 32'(sdo4r1), 32'd1);
    reset = 1'b0;
    pexp_r1 = 7'b1110000;
    for (int i = 6; i >= 0; i--) begin
      step(1'b0);
      check_val("mid_post_sdo4",   32'(sdo4),   32'd0);
      check_val("mid_post_sdo4r1", 32'(sdo4r1), 32'(pexp_r1[i]));
    end

    // Random sweep over all depths against the input history.
    reset = 1'b1;
    step(1'b1);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      b = 1'($urandom_range(0, 1));
      step(b);
      n++;
      hist[n] = b;
      check_val("sweep_sdo1",  32'(sdo1),  32'(exp_sdo(1)));
      check_val("sweep_sdo4",  32'(sdo4),  32'(exp_sdo(4)));
      check_val("sweep_sdo16", 32'(sdo16), 32'(exp_sdo(16)));
`ifdef SHIFT_REG_SISO_TAP_EN
      check_val("sweep_cnt16", 32'(cnt16), exp_cnt(16));
      check_val("sweep_cnt1",  32'(cnt1),  exp_cnt(1));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
